// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 32;
    localparam int unsigned XLEN       = 32;

    // RV32I size/sign encodings carried on req_funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Access captured at acceptance; offset is already alignment-forced
    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [1:0]      offset;
        logic [XLEN-1:0] wdata;
    } lsu_op_t;

    // Stores only know B/H/W; loads add the unsigned variants
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic sized;
        sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (we) begin
            return sized;
        end
        return sized || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Low address bits that do not match the access size
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extract/extend and store lane merge (purely combinational).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rd_word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data_c,
    output logic [XLEN-1:0] store_word_c
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] lane_word;
    logic [XLEN-1:0] lane_mask;

    assign shamt     = {offset, 3'b000};
    assign lane_word = rd_word >> shamt;

    // Bring the addressed lane down to bit 0 and extend it
    always_comb begin
        load_data_c = '0;
        case (funct3)
            F3_B:    load_data_c = {{24{lane_word[7]}}, lane_word[7:0]};
            F3_BU:   load_data_c = {24'h0, lane_word[7:0]};
            F3_H:    load_data_c = {{16{lane_word[15]}}, lane_word[15:0]};
            F3_HU:   load_data_c = {16'h0, lane_word[15:0]};
            F3_W:    load_data_c = rd_word;
            default: load_data_c = '0;
        endcase
    end

    // Replace only the addressed lanes of the old word with store data
    always_comb begin
        lane_mask = '0;
        case (funct3)
            F3_B:    lane_mask = 32'h0000_00FF << shamt;
            F3_H:    lane_mask = 32'h0000_FFFF << shamt;
            F3_W:    lane_mask = 32'hFFFF_FFFF;
            default: lane_mask = '0;
        endcase
        store_word_c = (rd_word & ~lane_mask) | ((wdata << shamt) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between core and a word-wide data memory.
// Sub-word stores are done as read-modify-write.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into error
// responses; otherwise the low address bits are forced to alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [XLEN-1:0]   mem_read_data
);

    lsu_state_e      state_q;
    lsu_state_e      state_nxt;
    lsu_op_t         op_q;
    logic            accept_c;
    logic            req_err_c;
    logic [1:0]      offset_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] store_word_c;

    assign accept_c = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err_c = !funct3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_err_c = !funct3_legal(req_we, req_funct3);
`endif

    // Force the lane offset to the access size's natural alignment
    always_comb begin
        offset_c = req_addr[1:0];
        case (req_funct3)
            F3_H, F3_HU: offset_c = {req_addr[1], 1'b0};
            F3_W:        offset_c = 2'b00;
            default:     offset_c = req_addr[1:0];
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state: loads read, SW writes, SB/SH read then write, errors respond at once
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err_c) begin
                        state_nxt = ST_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  state_nxt = op_q.we ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    lsu_align u_align (
        .funct3       (op_q.funct3),
        .offset       (op_q.offset),
        .rd_word      (mem_read_data),
        .wdata        (op_q.wdata),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // Capture the request at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
        end else if (accept_c) begin
            op_q <= '{we: req_we, funct3: req_funct3, offset: offset_c, wdata: req_wdata};
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            req_ready  <= (state_nxt == ST_IDLE);
            mem_read   <= (state_nxt == ST_READ);
            mem_write  <= (state_nxt == ST_WRITE);
            resp_valid <= (state_nxt == ST_RESP);
            resp_err   <= (state_q == ST_IDLE) && (state_nxt == ST_RESP);
            if (accept_c) begin
                mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                if (req_we) begin
                    mem_write_data <= req_wdata;
                end
            end
            if ((state_q == ST_READ) && (state_nxt == ST_WRITE)) begin
                mem_write_data <= store_word_c;
            end
            if (state_nxt == ST_RESP) begin
                resp_rdata <= (state_q == ST_READ) ? load_data_c : '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_read_data;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT
    logic [31:0] tb_mem    [0:63];
    // Reference copy updated by the model at issue time
    logic [31:0] model_mem [0:63];

    assign mem_read_data = tb_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[7:2]] <= mem_write_data;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic        chk;
        logic [5:0]  widx;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];

    int n_chk     = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int rd_cnt    = 0;
    int wr_cnt    = 0;
    int wr_total  = 0;
    int resp_cnt  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: invariants every cycle, full check on each response
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_exclusive", 32'(mem_read && mem_write), 32'd0);
            check("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
            check("mem_addr_range", mem_addr[31:8], 32'd0);
            if (mem_read)  rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                wr_total++;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    check("read_strobes", 32'(rd_cnt), 32'(e.nrd));
                    check("write_strobes", 32'(wr_cnt), 32'(e.nwr));
                    check("ready_in_resp", 32'(req_ready), 32'd0);
                    if (e.chk) check("mem_word", tb_mem[e.widx], e.word);
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                rd_cnt  = 0;
                wr_cnt  = 0;
            end
        end
    end

    // Reference model: what one access must produce, straight from the RV32I rules
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output exp_t r);
        logic        legal;
        logic        mis;
        int          size;
        logic [31:0] ea;
        logic [31:0] word;
        logic [7:0]  b [4];
        int          k;
        int          o;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (addr % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) legal = 1'b0;
`endif
        r.rdata = 32'd0; r.err = 1'b0; r.chk = 1'b0; r.widx = '0; r.word = 32'd0;
        if (!legal) begin
            r.err = 1'b1; r.lat = 1; r.nrd = 0; r.nwr = 0;
            return;
        end
        ea   = addr - (addr % size);
        word = model_mem[ea[7:2]];
        for (k = 0; k < 4; k++) b[k] = word[8*k +: 8];
        o = int'(ea % 4);
        if (!we) begin
            r.lat = 2; r.nrd = 1; r.nwr = 0;
            if (size == 1)      r.rdata = {24'd0, b[o]};
            else if (size == 2) r.rdata = {16'd0, b[o+1], b[o]};
            else                r.rdata = word;
            if (f3 == 3'd0 && r.rdata >= 32'h80)   r.rdata = r.rdata + 32'hFFFF_FF00;
            if (f3 == 3'd1 && r.rdata >= 32'h8000) r.rdata = r.rdata + 32'hFFFF_0000;
        end else begin
            if (size == 4) begin
                r.lat = 2; r.nrd = 0; r.nwr = 1;
                word  = wdata;
            end else begin
                r.lat = 3; r.nrd = 1; r.nwr = 1;
                b[o] = wdata[7:0];
                if (size == 2) b[o+1] = wdata[15:8];
                word = {b[3], b[2], b[1], b[0]};
            end
            model_mem[ea[7:2]] = word;
            r.chk = 1'b1; r.widx = ea[7:2]; r.word = word;
        end
    endtask

    // Issue one access; returns in the response cycle (after the negedge sample)
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
        exp_t r;
        int   tries;
        int   target;
        model_access(we, f3, addr, wdata, r);
        exp_q.push_back(r);
        target = resp_cnt + 1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tries = 0;
        while (!req_ready && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1");
            void'(exp_q.pop_back());
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        tries = 0;
        while (resp_cnt < target && tries < 10) begin
            @(negedge clk); #1;
            tries++;
        end
        req_valid = 1'b0;
        if (resp_cnt < target) begin
            n_chk++; n_fail++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 10 cycles");
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [10];
    int   wr0;
    int   rc0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]    = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
            model_mem[i] = tb_mem[i];
        end
        tb_mem[4]    = 32'h8077_F0A5;
        model_mem[4] = 32'h8077_F0A5;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // Sign/zero extension from a known word
        issue(1'b0, F3_B, 32'h11, 32'd0, 1'b0);
        check("lit_lb_0x11", resp_rdata, 32'hFFFF_FFF0);
        idle(2);
        check("rdata_holds", resp_rdata, 32'hFFFF_FFF0);
        issue(1'b0, F3_BU, 32'h11, 32'd0, 1'b0);
        check("lit_lbu_0x11", resp_rdata, 32'h0000_00F0);
        idle(1);

        // Halfword RMW into the upper lanes
        issue(1'b1, F3_H, 32'h12, 32'h0000_1234, 1'b0);
        check("lit_sh_word", tb_mem[4], 32'h1234_F0A5);
        check("lit_sh_rdata", resp_rdata, 32'd0);
        idle(1);
        issue(1'b0, F3_H, 32'h12, 32'd0, 1'b0);
        check("lit_lh_0x12", resp_rdata, 32'h0000_1234);
        issue(1'b0, F3_H, 32'h10, 32'd0, 1'b0);
        check("lit_lh_0x10", resp_rdata, 32'hFFFF_F0A5);
        issue(1'b0, F3_HU, 32'h10, 32'd0, 1'b0);
        check("lit_lhu_0x10", resp_rdata, 32'h0000_F0A5);

        // Word store then read back, then byte RMW in the top lane
        issue(1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, F3_W, 32'h20, 32'd0, 1'b0);
        check("lit_lw_0x20", resp_rdata, 32'hDEAD_BEEF);
        issue(1'b1, F3_B, 32'h23, 32'h0000_007F, 1'b0);
        check("lit_sb_word", tb_mem[8], 32'h7FAD_BEEF);
        issue(1'b0, F3_B, 32'h21, 32'd0, 1'b0);
        check("lit_lb_0x21", resp_rdata, 32'hFFFF_FFBE);

        // Misaligned word load
        issue(1'b0, F3_W, 32'h22, 32'd0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lit_lw_mis_err", 32'(resp_err), 32'd1);
`else
        check("lit_lw_mis_err", 32'(resp_err), 32'd0);
        check("lit_lw_mis_data", resp_rdata, 32'h7FAD_BEEF);
`endif

        // Illegal encodings
        issue(1'b0, 3'b011, 32'h10, 32'd0, 1'b0);
        check("lit_illegal_load", 32'(resp_err), 32'd1);
        issue(1'b1, 3'b101, 32'h10, 32'h1111_1111, 1'b0);
        check("lit_illegal_store", 32'(resp_err), 32'd1);

        // Misaligned halfword store
        issue(1'b1, F3_H, 32'h11, 32'h0000_ABCD, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
        check("lit_sh_mis_word", tb_mem[4], 32'h1234_ABCD);
`endif

        // Reset while an SB sits in READ
        idle(1);
        wr0 = wr_total; rc0 = resp_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h31; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_read", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mem_read", 32'(mem_read), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        idle(4);
        check("abort_no_write", 32'(wr_total - wr0), 32'd0);
        check("abort_no_resp", 32'(resp_cnt - rc0), 32'd0);
        check("abort_mem_kept", tb_mem[12], model_mem[12]);

        // Request held through a busy access: one response only
        rc0 = resp_cnt;
        issue(1'b0, F3_W, 32'h10, 32'd0, 1'b1);
        idle(4);
        check("held_one_resp", 32'(resp_cnt - rc0), 32'd1);

        // Mixed directed vectors checked by the model only
        vecs[0] = '{1'b1, F3_B, 32'h40, 32'hAAAA_AA81};
        vecs[1] = '{1'b0, F3_B, 32'h40, 32'd0};
        vecs[2] = '{1'b0, F3_BU, 32'h40, 32'd0};
        vecs[3] = '{1'b1, F3_H, 32'h46, 32'h0000_8001};
        vecs[4] = '{1'b0, F3_H, 32'h46, 32'd0};
        vecs[5] = '{1'b0, F3_W, 32'h44, 32'd0};
        vecs[6] = '{1'b1, F3_W, 32'hFC, 32'h0123_4567};
        vecs[7] = '{1'b0, F3_HU, 32'hFE, 32'd0};
        vecs[8] = '{1'b0, 3'b111, 32'h40, 32'd0};
        vecs[9] = '{1'b1, F3_B, 32'hFF, 32'h0000_00EE};
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0);
        end
        check("lit_final_word", tb_mem[63], 32'hEE23_4567);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width on both the core and memory sides.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core access request.
REQ-005 req_ready  output  1  LSU idle and able to accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, sign- or zero-extended; 0 for stores.
REQ-012 resp_err  output  1  misaligned or illegal access; valid only with resp_valid.
REQ-013 mem_addr  output  ADDR_W  word-aligned address to data memory, bits [1:0] = 0.
REQ-014 mem_write_data  output  32  full word to data memory.
REQ-015 mem_read  output  1  read enable to data memory.
REQ-016 mem_write  output  1  write enable to data memory; the write commits at posedge.
REQ-017 mem_read_data  input  32  combinational word read from data memory.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 A request is accepted on a posedge with req_valid && req_ready; addr, we, funct3 and wdata are registered at acceptance.
REQ-020 Load: IDLE->READ->RESP; mem_read = 1 only in READ; the selected lane is extracted and extended into resp_rdata at the READ->RESP edge.
REQ-021 SW: IDLE->WRITE->RESP; mem_write = 1 only in WRITE, with mem_write_data = wdata.
REQ-022 SB/SH: IDLE->READ->WRITE->RESP (read-modify-write); the old word is captured in READ; WRITE merges only the addressed byte or halfword lanes.
REQ-023 resp_valid SHALL be high exactly one cycle, in RESP; RESP->IDLE unconditionally.
REQ-024 Latency from the accept edge to resp_valid high: 2 cycles for loads and SW, 3 cycles for SB/SH, 1 cycle for error responses.
REQ-025 mem_read and mem_write SHALL never be high in the same cycle, and both are 0 in IDLE and RESP.
REQ-026 A halfword at addr[1] selects lanes [31:16] or [15:0]; a byte at addr[1:0] selects lane 8*addr[1:0].
REQ-027 An illegal funct3 (loads 011/110/111, stores 011-111) SHALL go IDLE->RESP with resp_err = 1 and no memory access.
REQ-028 req_valid outside IDLE is ignored; the request is not queued.
REQ-029 resp_rdata SHALL hold its value until the next RESP.

Reset
REQ-030 While rst is high: state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_write_data = 0.
REQ-031 Reset mid-operation SHALL abort the access with no response; an RMW aborted in READ SHALL issue no write.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: halfword accesses with addr[0] = 1 and word accesses with addr[1:0] != 0 SHALL go IDLE->RESP with resp_err = 1 and no memory access.
REQ-033 Macro LSU_MISALIGN_TRAP_EN undefined: the low address bits are forced to alignment (H clears bit 0, W clears bits 1:0), the access proceeds normally, and resp_err = 0.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum, the funct3 encodings, and the ADDR_W default.
REQ-035 Sub-module lsu_align (combinational) SHALL perform load lane extract/extend and store lane merge.

Verification
REQ-036 Memory word 0x10 = 0x8077_F0A5; LB at 0x11 -> resp_rdata = 0xFFFF_FFF0; LBU at 0x11 -> 0x0000_00F0; resp_valid 2 cycles after accept.
REQ-037 SH 0x1234 at 0x12 over 0x8077_F0A5 -> one mem_write of 0x1234_F0A5 to mem_addr 0x10; resp_valid 3 cycles after accept.
REQ-038 SW 0xDEAD_BEEF at 0x20 -> mem_read never asserted, one mem_write, then LW at 0x20 returns 0xDEAD_BEEF.
REQ-039 LW at 0x22 with LSU_MISALIGN_TRAP_EN -> resp_err = 1 one cycle after accept, no mem_read; without the macro -> reads 0x20 with resp_err = 0.
REQ-040 rst asserted while in READ during SB -> state IDLE, no mem_write, no resp_valid; the next request is accepted normally.
REQ-041 req_funct3 = 011 load -> resp_err = 1, no memory strobes; req_valid held during a busy access -> exactly one response per accepted request.
